// File: rtl/lut_mux_pkg.sv
// Shared types and helpers for the run-time loadable truth-table evaluator.
package lut_mux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SWEEP = 2'd2
  } state_t;

  function automatic int tbl_depth(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/lut_mux_tree.sv
// Combinational 2^N_IN:1 selector built as a binary tree of 2:1 muxes.
module lut_mux_tree
  import lut_mux_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic [tbl_depth(N_IN)-1:0] tbl,
  input  logic [N_IN-1:0]            sel,
  output logic                       y
);

  genvar gd, gi;
  generate
    // Level gd holds 2^gd nodes; the deepest level is the table itself.
    for (gd = 0; gd <= N_IN; gd++) begin : g_lvl
      logic [(1<<gd)-1:0] v;
      if (gd == N_IN) begin : g_leaf
        assign v = tbl;
      end else begin : g_node
        for (gi = 0; gi < (1 << gd); gi++) begin : g_mux
          assign v[gi] = sel[N_IN-1-gd] ? g_lvl[gd+1].v[2*gi+1] : g_lvl[gd+1].v[2*gi];
        end
      end
    end
  endgenerate

  assign y = g_lvl[0].v[0];

endmodule

// File: rtl/lut_mux_eval.sv
// Registered truth-table evaluator: single lookups, serial table load and
// full-code sweep, all sharing one mux tree.
module lut_mux_eval
  import lut_mux_pkg::*;
#(
  parameter int                          N_IN       = 3,
  parameter logic [tbl_depth(N_IN)-1:0]  INIT_TABLE = 8'h14
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_start,
  input  logic            load_bit,
  input  logic            load_valid,
  input  logic            eval_valid,
  input  logic [N_IN-1:0] eval_in,
  input  logic            sweep_start,
  output logic            out_valid,
  output logic [N_IN-1:0] out_in,
  output logic            out_y,
  output logic            busy,
  output logic            sweep_done
);

  localparam int DEPTH = tbl_depth(N_IN);

  state_t            state_reg, state_next;
  logic [DEPTH-1:0]  table_reg, shadow_reg, shadow_next;
  logic [N_IN:0]     load_cnt_reg, load_cnt_inc;
  logic [N_IN-1:0]   sweep_cnt_reg;
  logic [N_IN-1:0]   mux_sel;
  logic              mux_y;
  logic              load_last, sweep_last, eval_take, result_take;

  lut_mux_tree #(.N_IN(N_IN)) u_tree (
    .tbl (table_reg),
    .sel (mux_sel),
    .y   (mux_y)
  );

  always_comb begin
    state_next   = state_reg;
    shadow_next  = shadow_reg;
    shadow_next[load_cnt_reg[N_IN-1:0]] = load_bit;
    load_cnt_inc = load_cnt_reg + 1'b1;
    load_last    = (state_reg == LOAD) && load_valid && (load_cnt_inc == (N_IN+1)'(DEPTH));
    sweep_last   = (state_reg == SWEEP) && (sweep_cnt_reg == '1);
    eval_take    = eval_valid && (state_reg != SWEEP);
    result_take  = eval_take || (state_reg == SWEEP);
    mux_sel      = (state_reg == SWEEP) ? sweep_cnt_reg : eval_in;
    case (state_reg)
      IDLE: begin
        if (load_start)       state_next = LOAD;
        else if (sweep_start) state_next = SWEEP;
      end
      LOAD:    if (load_last)  state_next = IDLE;
      SWEEP:   if (sweep_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      table_reg     <= INIT_TABLE;
      shadow_reg    <= '0;
      load_cnt_reg  <= '0;
      sweep_cnt_reg <= '0;
      out_valid     <= 1'b0;
      out_in        <= '0;
      out_y         <= 1'b0;
      sweep_done    <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (load_start) begin
            shadow_reg   <= '0;
            load_cnt_reg <= '0;
          end
        end
        LOAD: begin
          if (load_valid) begin
            shadow_reg   <= shadow_next;
            load_cnt_reg <= load_last ? '0 : load_cnt_inc;
          end
          // Commit includes the bit arriving on this same edge.
          if (load_last) table_reg <= shadow_next;
        end
        SWEEP:   sweep_cnt_reg <= sweep_cnt_reg + 1'b1;
        default: ;
      endcase
      out_valid  <= result_take;
      sweep_done <= sweep_last;
      if (result_take) begin
        out_in <= mux_sel;
        out_y  <= mux_y;
      end
    end
  end

endmodule

// File: tb/tb_lut_mux_eval.sv
// Directed self-checking bench for lut_mux_eval (N_IN = 3, 1 and 4 instances).
module tb_lut_mux_eval;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       load_start, load_bit, load_valid, eval_valid, sweep_start;
  logic [2:0] eval_in;
  logic       out_valid, out_y, busy, sweep_done;
  logic [2:0] out_in;

  logic       d1_load_start, d1_load_bit, d1_load_valid, d1_eval_valid, d1_sweep_start;
  logic [0:0] d1_eval_in, d1_out_in;
  logic       d1_out_valid, d1_out_y, d1_busy, d1_sweep_done;

  logic       d4_load_start, d4_load_bit, d4_load_valid, d4_eval_valid, d4_sweep_start;
  logic [3:0] d4_eval_in, d4_out_in;
  logic       d4_out_valid, d4_out_y, d4_busy, d4_sweep_done;

  int errors = 0;
  int checks = 0;

  lut_mux_eval #(.N_IN(3), .INIT_TABLE(8'h14)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_bit(load_bit),
    .load_valid(load_valid), .eval_valid(eval_valid), .eval_in(eval_in),
    .sweep_start(sweep_start), .out_valid(out_valid), .out_in(out_in),
    .out_y(out_y), .busy(busy), .sweep_done(sweep_done)
  );

  lut_mux_eval #(.N_IN(1), .INIT_TABLE(2'b01)) dut1 (
    .clk(clk), .rst_n(rst_n), .load_start(d1_load_start), .load_bit(d1_load_bit),
    .load_valid(d1_load_valid), .eval_valid(d1_eval_valid), .eval_in(d1_eval_in),
    .sweep_start(d1_sweep_start), .out_valid(d1_out_valid), .out_in(d1_out_in),
    .out_y(d1_out_y), .busy(d1_busy), .sweep_done(d1_sweep_done)
  );

  lut_mux_eval #(.N_IN(4), .INIT_TABLE(16'h0014)) dut4 (
    .clk(clk), .rst_n(rst_n), .load_start(d4_load_start), .load_bit(d4_load_bit),
    .load_valid(d4_load_valid), .eval_valid(d4_eval_valid), .eval_in(d4_eval_in),
    .sweep_start(d4_sweep_start), .out_valid(d4_out_valid), .out_in(d4_out_in),
    .out_y(d4_out_y), .busy(d4_busy), .sweep_done(d4_sweep_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Sweep the 3-input DUT and compare every result with the expected table.
  task automatic sweep_main(input logic [7:0] exp_tbl, input logic hold_eval, input string tag);
    sweep_start = 1'b1;
    tick;
    sweep_start = 1'b0;
    eval_valid  = hold_eval;
    eval_in     = 3'b101;
    check({tag, "_busy_start"}, busy, 1);
    for (int c = 0; c < 8; c++) begin
      tick;
      check($sformatf("%s_valid%0d", tag, c), out_valid, 1);
      check($sformatf("%s_in%0d", tag, c), out_in, c);
      check($sformatf("%s_y%0d", tag, c), out_y, exp_tbl[c]);
      check($sformatf("%s_done%0d", tag, c), sweep_done, (c == 7));
      check($sformatf("%s_busy%0d", tag, c), busy, (c != 7));
    end
    eval_valid = 1'b0;
    tick;
    check({tag, "_valid_after"}, out_valid, 0);
    check({tag, "_done_after"}, sweep_done, 0);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic load_main(input logic [7:0] val);
    load_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      load_bit = val[i];
      tick;
    end
    load_valid = 1'b0;
  endtask

  initial begin
    logic [7:0]  maj;
    logic [1:0]  t1;
    logic [15:0] v4;
    maj = 8'hE8;
    t1  = 2'b01;
    v4  = 16'hA5A5;

    rst_n = 1'b0;
    {load_start, load_bit, load_valid, eval_valid, sweep_start} = '0;
    eval_in = '0;
    {d1_load_start, d1_load_bit, d1_load_valid, d1_eval_valid, d1_sweep_start} = '0;
    d1_eval_in = '0;
    {d4_load_start, d4_load_bit, d4_load_valid, d4_eval_valid, d4_sweep_start} = '0;
    d4_eval_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_in", out_in, 0);
    check("rst_y", out_y, 0);
    check("rst_busy", busy, 0);
    check("rst_done", sweep_done, 0);
    rst_n = 1'b1;

    // 1: default table sweep
    sweep_main(8'h14, 1'b0, "t1");

    // 2: single lookups, back to back
    eval_valid = 1'b1;
    eval_in    = 3'b100;
    tick;
    check("t2_valid_a", out_valid, 1);
    check("t2_in_a", out_in, 3'b100);
    check("t2_y_a", out_y, 1);
    eval_in = 3'b111;
    tick;
    check("t2_valid_b", out_valid, 1);
    check("t2_in_b", out_in, 3'b111);
    check("t2_y_b", out_y, 0);
    eval_valid = 1'b0;
    tick;
    check("t2_valid_idle", out_valid, 0);
    check("t2_in_hold", out_in, 3'b111);

    // 3: load majority table; lookups before and on the commit edge see the old table
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    check("t3_busy_load", busy, 1);
    load_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      load_bit   = maj[i];
      eval_valid = (i == 3);
      eval_in    = 3'b101;
      tick;
      if (i == 3) begin
        check("t3_mid_valid", out_valid, 1);
        check("t3_mid_y", out_y, 0);
      end
    end
    load_bit   = maj[7];
    eval_valid = 1'b1;
    eval_in    = 3'b011;
    tick;
    load_valid = 1'b0;
    check("t3_commit_valid", out_valid, 1);
    check("t3_commit_in", out_in, 3'b011);
    check("t3_commit_y", out_y, 0);
    check("t3_commit_busy", busy, 0);
    tick;
    check("t3_new_y", out_y, 1);
    eval_valid = 1'b0;
    tick;
    sweep_main(maj, 1'b0, "t3");

    // 4: partial load of all-ones, then asynchronous reset restores the default table
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    load_valid = 1'b1;
    load_bit   = 1'b1;
    repeat (4) tick;
    load_valid = 1'b0;
    check("t4_busy_pre", busy, 1);
    rst_n = 1'b0;
    #2;
    check("t4_async_busy", busy, 0);
    check("t4_async_in", out_in, 0);
    #2;
    rst_n      = 1'b1;
    eval_valid = 1'b1;
    eval_in    = 3'b010;
    tick;
    check("t4_y_010", out_y, 1);
    eval_in = 3'b011;
    tick;
    check("t4_y_011", out_y, 0);
    eval_valid = 1'b0;
    // load_valid while idle must not touch the table
    load_valid = 1'b1;
    load_bit   = 1'b1;
    repeat (9) tick;
    load_valid = 1'b0;
    check("t4_idle_load_busy", busy, 0);
    eval_valid = 1'b1;
    eval_in    = 3'b011;
    tick;
    eval_valid = 1'b0;
    check("t4_idle_load_y", out_y, 0);

    // 5: simultaneous start pulses favour LOAD; evals are ignored during SWEEP
    load_start  = 1'b1;
    sweep_start = 1'b1;
    tick;
    load_start  = 1'b0;
    sweep_start = 1'b0;
    check("t5_busy", busy, 1);
    check("t5_no_result0", out_valid, 0);
    tick;
    check("t5_no_result1", out_valid, 0);
    load_main(8'h96);
    check("t5_load_done_busy", busy, 0);
    sweep_main(8'h96, 1'b1, "t5");

    // 6a: single-input instance
    d1_sweep_start = 1'b1;
    tick;
    d1_sweep_start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick;
      check($sformatf("t6a_valid%0d", c), d1_out_valid, 1);
      check($sformatf("t6a_in%0d", c), d1_out_in, c);
      check($sformatf("t6a_y%0d", c), d1_out_y, t1[c]);
      check($sformatf("t6a_done%0d", c), d1_sweep_done, (c == 1));
    end

    // 6b: four-input instance with a loaded table
    d4_load_start = 1'b1;
    tick;
    d4_load_start = 1'b0;
    d4_load_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      d4_load_bit = v4[i];
      tick;
    end
    d4_load_valid = 1'b0;
    check("t6b_load_busy", d4_busy, 0);
    d4_sweep_start = 1'b1;
    tick;
    d4_sweep_start = 1'b0;
    for (int c = 0; c < 16; c++) begin
      tick;
      check($sformatf("t6b_in%0d", c), d4_out_in, c);
      check($sformatf("t6b_y%0d", c), d4_out_y, v4[c]);
      check($sformatf("t6b_done%0d", c), d4_sweep_done, (c == 15));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
